sha_core: RTL and testbench
===========================

Name: sha_core

Overview:
- Single-block SHA-256 compression engine. It hashes one pre-padded 512-bit message block, starting from the standard FIPS 180-4 initial hash value (IV).
- Sits behind a bus wrapper that assembles the 512-bit block and pulses start.
- Computes one round per clock, then presents a 256-bit digest with a valid flag.

Parameters:
- None. All SHA-256 constants are fixed: K[0..63] and IV H0..H7.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- clr  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request; sampled on a rising edge while idle.
- message  input  512  padded block; bits [511:480] = W0, bits [31:0] = W15 (big-endian words).
- hashvalue  output  256  digest; bits [255:224] = H0 … bits [31:0] = H7.
- valid  output  1  high while hashvalue holds a completed digest.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, round counter=0, hashvalue=0, valid=0.
  - Working regs a..h and the W window are cleared.
  - Reset has priority over everything, including mid-computation; the computation is abandoned and no valid follows.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - On an edge with start=1: load the W window with message[511:0] (16 words), load a..h with the IV, clear the round counter, clear valid, go to ROUND.
  - valid/hashvalue keep their previous values until that load.
- ROUND: each edge performs round t = counter (0..63):
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
  - All additions are mod 2^32.
- Message schedule: 16-word sliding window.
  - Rounds 0..15 use the loaded words.
  - For t≥16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]. Compute it in the same cycle the window shifts.
- Functions:
  - Σ0 = ROTR2^ROTR13^ROTR22
  - Σ1 = ROTR6^ROTR11^ROTR25
  - σ0 = ROTR7^ROTR18^SHR3
  - σ1 = ROTR17^ROTR19^SHR10
  - Ch = (e&f)^(~e&g)
  - Maj = (a&b)^(a&c)^(b&c)
- After round 63 (counter=63 edge) go to FINAL.
- FINAL (one edge): hashvalue ← {IV0+a, …, IV7+h} (each mod 2^32), valid←1, go to IDLE.
- Latency: if start is sampled at edge E0, rounds occur at E1..E64 and hashvalue/valid update at E65.
- valid stays high, and hashvalue stable, until the next accepted start or reset.
- start while in ROUND or FINAL is ignored; no queuing.
- start held high for multiple cycles: only re-accepted once back in IDLE, which starts a new hash of the current message.
- message only needs to be stable on the accepting edge.
- No chaining: every start begins from the IV. Multi-block messages are out of scope.
- No padding logic: the caller supplies a fully padded block.

Decomposition:
- Package sha256_pkg holds:
  - the K[0..63] constant array;
  - the IV H0..H7 constants;
  - functions for the Σ0/Σ1/σ0/σ1/Ch/Maj primitives;
  - the state enum (IDLE, ROUND, FINAL).
- One natural sub-module: sha256_msg_sched.
  - Contains the 16×32-bit window, load on start, shift/expand on each round.
  - Outputs the current W[t].
- Round datapath and FSM stay in sha_core.

Test Plan:
- "abc" block (message = 0x61626380, then 14 zero words, then 0x00000018; pulse start one cycle after clr deasserts) -> valid rises 65 edges after the start edge; hashvalue = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty string (message = 0x80000000 followed by fifteen zero words) -> hashvalue = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, valid=1.
- Reset values: clr=0 at time 0 -> hashvalue=0, valid=0 immediately (asynchronous, before any clock edge).
- Reset mid-operation: assert clr=0 at round 30, release, wait 100 cycles with start=0 -> valid stays 0. Then issue a fresh "abc" start -> correct digest.
- Start while busy: pulse start with the empty-string block during round 10 of an "abc" job -> the "abc" digest appears on schedule and the second request is ignored (valid remains high, hashvalue unchanged).
- Back-to-back jobs: after the "abc" valid, issue an empty-string start -> valid drops on the accepting edge and returns 65 edges later with the e3b0… digest. This confirms the IV is reloaded with no chaining.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, round primitives and FSM state type shared by the
// compression core and its message-schedule sub-module.
//   K[0..63]  round constants
//   IV[0..7]  initial hash value H0..H7
//   big_sigma0/1, small_sigma0/1, ch, maj  round/schedule primitives
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam int unsigned LAST_ROUND = 63;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: a 16-word sliding window holding W[t..t+15].
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears the window
//   i_load     load the window from i_message (W0 in bits [511:480])
//   i_shift    advance one round, appending W[t+16]
//   i_message  512-bit padded block
//   o_w        W[t] for the current round
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [511:0] i_message,
  output logic [31:0]  o_w
);

  logic [31:0] r_win [16];
  logic [31:0] w_next;

  // With the window holding W[t..t+15], this is W[t+16]. Words produced
  // during the last 16 rounds are never consumed, which is harmless.
  assign w_next = small_sigma1(r_win[14]) + r_win[9] + small_sigma0(r_win[1]) + r_win[0];
  assign o_w    = r_win[0];

  // NOTE: the window is plain flops, not a RAM, so it can be cleared by the
  // async reset; a RAM-style array would be left out of the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < 16; i++) r_win[i] <= i_message[511 - 32*i -: 32];
    end else if (i_shift) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_next;
    end
  end

endmodule

// File: rtl/sha_core.sv
// Single-block SHA-256 compression engine, one round per clock.
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   start      one-cycle request, accepted only while idle
//   message    padded 512-bit block, W0 in bits [511:480]
//   hashvalue  digest, H0 in bits [255:224]
//   valid      high while hashvalue holds a completed digest
// Start accepted at edge E0 -> rounds at E1..E64 -> digest/valid at E65.
module sha_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [511:0] message,
  output logic [255:0] hashvalue,
  output logic         valid
);

  state_t        r_state;
  logic [5:0]    r_round;
  logic [31:0]   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [255:0]  r_hash;
  logic          r_valid;

  logic          w_load;
  logic          w_shift;
  logic [31:0]   w_w;
  logic [31:0]   w_t1;
  logic [31:0]   w_t2;

  assign w_load  = (r_state == ST_IDLE) && start;
  assign w_shift = (r_state == ST_ROUND);

  sha256_msg_sched u_msg_sched (
    .clk       (clk),
    .rst_n     (clr),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_message (message),
    .o_w       (w_w)
  );

  assign w_t1 = r_h + big_sigma1(r_e) + ch(r_e, r_f, r_g) + K[r_round] + w_w;
  assign w_t2 = big_sigma0(r_a) + maj(r_a, r_b, r_c);

  assign hashvalue = r_hash;
  assign valid     = r_valid;

  // NOTE: non-blocking assignments make every register below sample the
  // pre-edge values, so the a..h rotation needs no temporaries.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_e     <= '0;
      r_f     <= '0;
      r_g     <= '0;
      r_h     <= '0;
      r_hash  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= IV[0];
            r_b     <= IV[1];
            r_c     <= IV[2];
            r_d     <= IV[3];
            r_e     <= IV[4];
            r_f     <= IV[5];
            r_g     <= IV[6];
            r_h     <= IV[7];
            r_round <= '0;
            r_valid <= 1'b0;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_h     <= r_g;
          r_g     <= r_f;
          r_f     <= r_e;
          r_e     <= r_d + w_t1;
          r_d     <= r_c;
          r_c     <= r_b;
          r_b     <= r_a;
          r_a     <= w_t1 + w_t2;
          r_round <= r_round + 6'd1;
          if (r_round == 6'(LAST_ROUND)) r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          r_hash  <= {IV[0] + r_a, IV[1] + r_b, IV[2] + r_c, IV[3] + r_d,
                      IV[4] + r_e, IV[5] + r_f, IV[6] + r_g, IV[7] + r_h};
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_core.sv
// Directed bench for sha_core: known-answer digests, latency, reset
// behaviour, start-while-busy and back-to-back jobs. Expected digests are
// queued when a job is launched and popped when valid rises.
module tb_sha_core;

  localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam int LATENCY = 65;

  logic         clk     = 1'b0;
  logic         clr     = 1'b1;
  logic         start   = 1'b0;
  logic [511:0] message = '0;
  logic [255:0] hashvalue;
  logic         valid;

  int n_vec = 0;
  int n_err = 0;
  logic [255:0] exp_q [$];

  sha_core dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .message   (message),
    .hashvalue (hashvalue),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives start for one cycle and returns #1 after the accepting edge E0.
  // The message is scrambled afterwards: it only has to be stable at E0.
  task automatic launch(input string tag, input logic [511:0] msg, input logic [255:0] dig);
    @(negedge clk);
    start   = 1'b1;
    message = msg;
    exp_q.push_back(dig);
    @(posedge clk);
    #1;
    start   = 1'b0;
    message = {16{$urandom()}};
    check({tag, "_valid_drop"}, 256'(valid), 256'd0);
  endtask

  // Counts edges after E0 until valid rises (bounded). If pulse_at > 0, a
  // start with msg2 is driven so that it is sampled on edge pulse_at.
  task automatic await_done(input string tag, input int pulse_at, input logic [511:0] msg2);
    int n;
    logic [255:0] exp;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      if (i == pulse_at) begin
        start   = 1'b1;
        message = msg2;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (valid) begin
        n = i;
        break;
      end
    end
    check({tag, "_latency"}, 256'(n), 256'(LATENCY));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_digest"}, hashvalue, exp);
  endtask

  initial begin
    int seen_valid;

    // Asynchronous reset at time 0, checked before any rising edge.
    clr = 1'b0;
    #1;
    check("reset_hash", hashvalue, 256'd0);
    check("reset_valid", 256'(valid), 256'd0);

    // "abc", start one cycle after reset release.
    @(negedge clk);
    clr = 1'b1;
    launch("abc", MSG_ABC, DIG_ABC);
    await_done("abc", 0, '0);

    // Back-to-back: empty string right after; old digest held until FINAL.
    launch("empty", MSG_EMPTY, DIG_EMPTY);
    check("empty_hash_held", hashvalue, DIG_ABC);
    await_done("empty", 0, '0);

    // Start with the empty block during round 10 of an "abc" job: ignored.
    launch("busy", MSG_ABC, DIG_ABC);
    await_done("busy", 11, MSG_EMPTY);
    repeat (5) @(posedge clk);
    #1;
    check("busy_valid_hold", 256'(valid), 256'd1);
    check("busy_hash_hold", hashvalue, DIG_ABC);

    // Reset during round 30: job abandoned, no valid afterwards.
    launch("midrst", MSG_ABC, DIG_ABC);
    repeat (30) @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("midrst_valid", 256'(valid), 256'd0);
    check("midrst_hash", hashvalue, 256'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    clr = 1'b1;
    seen_valid = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (valid) seen_valid = 1;
    end
    check("midrst_no_valid", 256'(seen_valid), 256'd0);

    // Fresh job after the abandoned one.
    launch("fresh", MSG_ABC, DIG_ABC);
    await_done("fresh", 0, '0);

    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case something above blocks unexpectedly.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
